// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    VALID
  } fetch_state_t;

  localparam int DEFAULT_ACK_TIMEOUT = 15;

  localparam logic [7:0] ADDR_INC_BYTE = 8'd1;
  localparam logic [7:0] ADDR_INC_WORD = 8'd2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Byte-wide instruction memory req/ack bus between the fetch unit and memory.
interface instr_fetch_unit_if;

  logic       MEM_REQ;
  logic [7:0] MEM_ADDR;
  logic       MEM_ACK;
  logic [7:0] MEM_DATA;

  modport master (
    output MEM_REQ,
    output MEM_ADDR,
    input  MEM_ACK,
    input  MEM_DATA
  );

  modport slave (
    input  MEM_REQ,
    input  MEM_ADDR,
    output MEM_ACK,
    output MEM_DATA
  );

endinterface

// File: rtl/instr_fetch_unit_ack_timer.sv
// Counts unacknowledged request cycles; expired flags the cycle that is the
// ACK_TIMEOUT-th unacked one, so the abort lands on the edge ending it.
module fetch_ack_timer
  import fetch_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (({1'b0, count} + 9'd1) == 9'(ACK_TIMEOUT));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the 16-bit instruction at PC from byte-wide memory and flags it on EN_L.
// Optional one-word prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [7:0]                PC,
  output logic [15:0]               Iin,
  output logic                      EN_L,
  output logic                      ERR,
  instr_fetch_unit_if.master        mem
);

  fetch_state_t state, state_n;

  logic [7:0]  tag, tag_n;
  logic        tag_v, tag_v_n;
  logic [7:0]  req_base, req_base_n;
  logic [7:0]  hi_byte, hi_byte_n;
  logic [15:0] iin_q, iin_n;
  logic        err_q, err_n;

  logic        in_flight;
  logic        miss;
  logic        holding;
  logic        expired;

`ifdef FETCH_PREFETCH_EN
  logic        pf_active, pf_active_n;
  logic        pf_v, pf_v_n;
  logic [7:0]  pf_tag, pf_tag_n;
  logic [15:0] pf_word, pf_word_n;
  logic [7:0]  next_word;

  assign next_word = tag + ADDR_INC_WORD;
  // A prefetch in flight still holds the current word, so EN_L stays low.
  assign holding   = (state == VALID) || pf_active;
`else
  assign holding   = (state == VALID);
`endif

  assign in_flight = (state == HI) || (state == LO);
  assign miss      = !tag_v || (PC != tag);

  assign mem.MEM_REQ  = in_flight;
  assign mem.MEM_ADDR = (state == HI) ? req_base :
                        (state == LO) ? (req_base + ADDR_INC_BYTE) : 8'h00;

  assign EN_L = !(holding && tag_v && (PC == tag));
  assign Iin  = iin_q;
  assign ERR  = err_q;

  fetch_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) ack_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (!in_flight || mem.MEM_ACK),
    .enable  (in_flight && !mem.MEM_ACK),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      tag      <= '0;
      tag_v    <= 1'b0;
      req_base <= '0;
      hi_byte  <= '0;
      iin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      tag      <= tag_n;
      tag_v    <= tag_v_n;
      req_base <= req_base_n;
      hi_byte  <= hi_byte_n;
      iin_q    <= iin_n;
      err_q    <= err_n;
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pf_active <= 1'b0;
      pf_v      <= 1'b0;
      pf_tag    <= '0;
      pf_word   <= '0;
    end else begin
      pf_active <= pf_active_n;
      pf_v      <= pf_v_n;
      pf_tag    <= pf_tag_n;
      pf_word   <= pf_word_n;
    end
  end
`endif

  always_comb begin
    state_n    = state;
    tag_n      = tag;
    tag_v_n    = tag_v;
    req_base_n = req_base;
    hi_byte_n  = hi_byte;
    iin_n      = iin_q;
    err_n      = err_q;
`ifdef FETCH_PREFETCH_EN
    pf_active_n = pf_active;
    pf_v_n      = pf_v;
    pf_tag_n    = pf_tag;
    pf_word_n   = pf_word;
`endif

    case (state)
      IDLE, VALID: begin
        if (!err_q && miss) begin
          tag_n   = PC;
          tag_v_n = 1'b1;
`ifdef FETCH_PREFETCH_EN
          if (pf_v && (PC == pf_tag)) begin
            iin_n   = pf_word;
            pf_v_n  = 1'b0;
            state_n = VALID;
          end else begin
            req_base_n = PC;
            state_n    = HI;
          end
`else
          req_base_n = PC;
          state_n    = HI;
`endif
        end
`ifdef FETCH_PREFETCH_EN
        else if ((state == VALID) && !(pf_v && (pf_tag == next_word))) begin
          req_base_n  = next_word;
          pf_active_n = 1'b1;
          pf_v_n      = 1'b0;
          state_n     = HI;
        end
`endif
      end

      HI, LO: begin
        if (expired) begin
          err_n   = 1'b1;
          tag_v_n = 1'b0;
          state_n = IDLE;
`ifdef FETCH_PREFETCH_EN
          pf_active_n = 1'b0;
          pf_v_n      = 1'b0;
`endif
        end else if (mem.MEM_ACK) begin
          // The byte in flight always completes; if PC moved it is dropped.
          if (miss) begin
            tag_n      = PC;
            tag_v_n    = 1'b1;
            req_base_n = PC;
            state_n    = HI;
`ifdef FETCH_PREFETCH_EN
            pf_active_n = 1'b0;
`endif
          end else if (state == HI) begin
            hi_byte_n = mem.MEM_DATA;
            state_n   = LO;
          end else begin
`ifdef FETCH_PREFETCH_EN
            if (pf_active) begin
              pf_word_n   = {hi_byte, mem.MEM_DATA};
              pf_tag_n    = req_base;
              pf_v_n      = 1'b1;
              pf_active_n = 1'b0;
            end else begin
              iin_n = {hi_byte, mem.MEM_DATA};
            end
`else
            iin_n = {hi_byte, mem.MEM_DATA};
`endif
            state_n = VALID;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte memory responder of
// programmable wait states; the unit runs with ACK_TIMEOUT=4.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  PC;
  logic [15:0] Iin;
  logic        EN_L;
  logic        ERR;

  instr_fetch_unit_if mem_bus ();

  instr_fetch_unit #(
    .ACK_TIMEOUT(TIMEOUT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .PC    (PC),
    .Iin   (Iin),
    .EN_L  (EN_L),
    .ERR   (ERR),
    .mem   (mem_bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem_image [256];
  int         wait_states = 0;
  logic       ack_en = 1'b1;
  int         wait_cnt = 0;
  int         tests_run = 0;
  int         tests_failed = 0;

  // Memory responder: acks after wait_states unacked cycles, data with the ack.
  always @(negedge CLK) begin
    if (mem_bus.MEM_REQ === 1'b1 && ack_en) begin
      if (wait_cnt >= wait_states) begin
        mem_bus.MEM_ACK  = 1'b1;
        mem_bus.MEM_DATA = mem_image[mem_bus.MEM_ADDR];
        wait_cnt         = 0;
      end else begin
        mem_bus.MEM_ACK  = 1'b0;
        mem_bus.MEM_DATA = 8'h00;
        wait_cnt         = wait_cnt + 1;
      end
    end else begin
      mem_bus.MEM_ACK  = 1'b0;
      mem_bus.MEM_DATA = 8'h00;
      wait_cnt         = 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the unit idle on the bus (lets any background fetch drain).
  task automatic settle();
    int n;
    n = 0;
    tick();
    while (mem_bus.MEM_REQ === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (mem_bus.MEM_REQ !== 1'b0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL settle: MEM_REQ got %b, expected 0 within 50 cycles", mem_bus.MEM_REQ);
    end
  endtask

  task automatic wait_en_low(input int max_cycles, output int cycles);
    int i;
    cycles = -1;
    i = 0;
    while (cycles < 0 && i < max_cycles) begin
      tick();
      i++;
      if (EN_L === 1'b0) cycles = i;
    end
  endtask

  task automatic test_reset();
    RESET  = 1'b1;
    PC     = 8'h00;
    ack_en = 1'b1;
    wait_states = 0;
    tick();
    tick();
    tests_run++;
    if (Iin !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_iin: got %h, expected 0000", Iin);
    end
    tests_run++;
    if (EN_L !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_en_l: got %b, expected 1", EN_L);
    end
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req: got %b, expected 0", mem_bus.MEM_REQ);
    end
    tests_run++;
    if (mem_bus.MEM_ADDR !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr: got %h, expected 00", mem_bus.MEM_ADDR);
    end
    tests_run++;
    if (ERR !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_err: got %b, expected 0", ERR);
    end
  endtask

  task automatic test_basic_fetch();
    RESET = 1'b0;
    PC    = 8'h00;
    #1;
    tests_run++;
    if (EN_L !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_cycle0_en_l: got %b, expected 1", EN_L);
    end
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b1 || mem_bus.MEM_ADDR !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL basic_cycle1_req: got req %b addr %h, expected req 1 addr 00",
               mem_bus.MEM_REQ, mem_bus.MEM_ADDR);
    end
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b1 || mem_bus.MEM_ADDR !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL basic_cycle2_req: got req %b addr %h, expected req 1 addr 01",
               mem_bus.MEM_REQ, mem_bus.MEM_ADDR);
    end
    tick();
    tests_run++;
    if (EN_L !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_cycle3_en_l: got %b, expected 0", EN_L);
    end
    tests_run++;
    if (Iin !== 16'h2A45) begin
      tests_failed++;
      $display("[TB] FAIL basic_iin: got %h, expected 2A45", Iin);
    end
  endtask

  task automatic test_wait_states();
    int          hi_cycles;
    int          lo_cycles;
    int          low_at;
    logic [15:0] held;
    settle();
    wait_states = 3;
    hi_cycles   = 0;
    lo_cycles   = 0;
    low_at      = -1;
    held        = 16'hxxxx;
    PC = 8'h10;
    #1;
    tests_run++;
    if (EN_L !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wait_en_l_same_cycle: got %b, expected 1", EN_L);
    end
    for (int c = 1; c <= 12 && low_at < 0; c++) begin
      tick();
      if (EN_L === 1'b0) begin
        low_at = c;
      end else begin
        if (mem_bus.MEM_REQ === 1'b1 && mem_bus.MEM_ADDR === 8'h10) hi_cycles++;
        if (mem_bus.MEM_REQ === 1'b1 && mem_bus.MEM_ADDR === 8'h11) lo_cycles++;
      end
      if (c == 4) held = Iin;
    end
    tests_run++;
    if (hi_cycles != 4) begin
      tests_failed++;
      $display("[TB] FAIL wait_hi_cycles: got %0d, expected 4", hi_cycles);
    end
    tests_run++;
    if (lo_cycles != 4) begin
      tests_failed++;
      $display("[TB] FAIL wait_lo_cycles: got %0d, expected 4", lo_cycles);
    end
    tests_run++;
    if (low_at != 9) begin
      tests_failed++;
      $display("[TB] FAIL wait_en_l_cycle: got %0d, expected 9", low_at);
    end
    tests_run++;
    if (held !== 16'h2A45) begin
      tests_failed++;
      $display("[TB] FAIL wait_iin_held: got %h, expected 2A45", held);
    end
    tests_run++;
    if (Iin !== 16'hA1B2) begin
      tests_failed++;
      $display("[TB] FAIL wait_iin: got %h, expected A1B2", Iin);
    end
  endtask

  task automatic test_wrap();
    settle();
    wait_states = 0;
    PC = 8'hFF;
    tick();
    tests_run++;
    if (mem_bus.MEM_ADDR !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL wrap_first_addr: got %h, expected FF", mem_bus.MEM_ADDR);
    end
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b1 || mem_bus.MEM_ADDR !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL wrap_second_addr: got req %b addr %h, expected req 1 addr 00",
               mem_bus.MEM_REQ, mem_bus.MEM_ADDR);
    end
    tick();
    tests_run++;
    if (EN_L !== 1'b0 || Iin !== 16'hC32A) begin
      tests_failed++;
      $display("[TB] FAIL wrap_iin: got en_l %b iin %h, expected en_l 0 iin C32A", EN_L, Iin);
    end
  endtask

  task automatic test_pc_change_mid_fetch();
    int cycles;
    settle();
    wait_states = 3;
    PC = 8'h04;
    tick();
    tests_run++;
    if (mem_bus.MEM_ADDR !== 8'h04) begin
      tests_failed++;
      $display("[TB] FAIL midfetch_first_addr: got %h, expected 04", mem_bus.MEM_ADDR);
    end
    tick();
    PC = 8'h20;
    #1;
    tests_run++;
    if (EN_L !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midfetch_en_l: got %b, expected 1", EN_L);
    end
    tick();
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b1 || mem_bus.MEM_ADDR !== 8'h04) begin
      tests_failed++;
      $display("[TB] FAIL midfetch_req_held: got req %b addr %h, expected req 1 addr 04",
               mem_bus.MEM_REQ, mem_bus.MEM_ADDR);
    end
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b1 || mem_bus.MEM_ADDR !== 8'h20) begin
      tests_failed++;
      $display("[TB] FAIL midfetch_new_addr: got req %b addr %h, expected req 1 addr 20",
               mem_bus.MEM_REQ, mem_bus.MEM_ADDR);
    end
    wait_en_low(20, cycles);
    tests_run++;
    if (cycles != 8) begin
      tests_failed++;
      $display("[TB] FAIL midfetch_latency: got %0d, expected 8", cycles);
    end
    tests_run++;
    if (Iin !== 16'h5A6B) begin
      tests_failed++;
      $display("[TB] FAIL midfetch_iin: got %h, expected 5A6B", Iin);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int cycles;
    settle();
    wait_states = 3;
    PC = 8'h30;
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_req_before: got %b, expected 1", mem_bus.MEM_REQ);
    end
    RESET = 1'b1;
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b0 || EN_L !== 1'b1 || Iin !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_after: got req %b en_l %b iin %h, expected req 0 en_l 1 iin 0000",
               mem_bus.MEM_REQ, EN_L, Iin);
    end
    RESET = 1'b0;
    wait_states = 0;
    PC = 8'h00;
    wait_en_low(10, cycles);
    tests_run++;
    if (cycles != 3 || Iin !== 16'h2A45) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_refetch: got cycle %0d iin %h, expected cycle 3 iin 2A45",
               cycles, Iin);
    end
  endtask

  task automatic test_timeout();
    int   req_cycles;
    int   req_seen;
    int   en_low_seen;
    logic err_at4;
    settle();
    ack_en     = 1'b0;
    req_cycles = 0;
    err_at4    = 1'bx;
    PC = 8'h40;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (mem_bus.MEM_REQ === 1'b1) req_cycles++;
      if (c == 4) err_at4 = ERR;
    end
    tests_run++;
    if (req_cycles != TIMEOUT || err_at4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_before: got req cycles %0d err %b, expected 4 and 0",
               req_cycles, err_at4);
    end
    tick();
    tests_run++;
    if (ERR !== 1'b1 || mem_bus.MEM_REQ !== 1'b0 || EN_L !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_edge: got err %b req %b en_l %b, expected 1 0 1",
               ERR, mem_bus.MEM_REQ, EN_L);
    end
    ack_en      = 1'b1;
    req_seen    = 0;
    en_low_seen = 0;
    PC = 8'h42;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_bus.MEM_REQ !== 1'b0) req_seen++;
      if (EN_L !== 1'b1) en_low_seen++;
    end
    tests_run++;
    if (req_seen != 0 || en_low_seen != 0 || ERR !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_halt: got req %0d en_l-low %0d err %b, expected 0 0 1",
               req_seen, en_low_seen, ERR);
    end
  endtask

  task automatic test_reset_clears_err();
    int cycles;
    RESET = 1'b1;
    tick();
    tests_run++;
    if (ERR !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_err: got %b, expected 0", ERR);
    end
    RESET = 1'b0;
    wait_states = 0;
    PC = 8'hFF;
    wait_en_low(10, cycles);
    tests_run++;
    if (cycles != 3 || Iin !== 16'hC32A) begin
      tests_failed++;
      $display("[TB] FAIL clear_refetch: got cycle %0d iin %h, expected cycle 3 iin C32A",
               cycles, Iin);
    end
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_prefetch();
    int cycles;
    settle();
    PC = 8'h00;
    wait_en_low(20, cycles);
    settle();
    PC = 8'h02;
    tick();
    tests_run++;
    if (EN_L !== 1'b0 || Iin !== 16'h7788) begin
      tests_failed++;
      $display("[TB] FAIL prefetch_hit: got en_l %b iin %h, expected en_l 0 iin 7788", EN_L, Iin);
    end
    tick();
    tests_run++;
    if (mem_bus.MEM_REQ !== 1'b1 || mem_bus.MEM_ADDR !== 8'h04) begin
      tests_failed++;
      $display("[TB] FAIL prefetch_next: got req %b addr %h, expected req 1 addr 04",
               mem_bus.MEM_REQ, mem_bus.MEM_ADDR);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem_image[i] = 8'(i ^ 8'h5C);
    mem_image[8'h00] = 8'h2A;
    mem_image[8'h01] = 8'h45;
    mem_image[8'h02] = 8'h77;
    mem_image[8'h03] = 8'h88;
    mem_image[8'h04] = 8'h11;
    mem_image[8'h05] = 8'h22;
    mem_image[8'h10] = 8'hA1;
    mem_image[8'h11] = 8'hB2;
    mem_image[8'h20] = 8'h5A;
    mem_image[8'h21] = 8'h6B;
    mem_image[8'hFF] = 8'hC3;

    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_wrap();
    test_pc_change_mid_fetch();
    test_reset_mid_fetch();
    test_timeout();
    test_reset_clears_err();
`ifdef FETCH_PREFETCH_EN
    test_prefetch();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream neighbour of `cpu`. It fetches each 16-bit instruction at the CPU's current `PC` from a byte-wide, variable-latency instruction memory over a req/ack handshake. It assembles the two bytes into `Iin` and reports readiness on the CPU's active-low `EN_L`. The CPU advances `PC` only while `EN_L` is low.

## Interface
- `ACK_TIMEOUT`, default 15: max cycles `MEM_REQ` may wait for `MEM_ACK` before abort; legal range 1–255.
- `CLK` in 1: clock; all state changes on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `PC` in 8: byte address of the instruction the CPU wants; may change on any cycle.
- `Iin` out 16: assembled instruction; `Iin[15:8]` = byte at `PC`, `Iin[7:0]` = byte at `PC+1`.
- `EN_L` out 1: low means `Iin` is the instruction at the current `PC`.
- `MEM_REQ` out 1: byte read request.
- `MEM_ADDR` out 8: byte address; stable while `MEM_REQ` is high and unacked.
- `MEM_ACK` in 1: memory accepts the request; `MEM_DATA` is valid in the same cycle.
- `MEM_DATA` in 8: read byte.
- `ERR` out 1: sticky timeout flag.

## Operation
- **States:**
  - `IDLE`: no valid word.
  - `HI`: fetching the high byte.
  - `LO`: fetching the low byte.
  - `VALID`: the word is held.
- **Registers:**
  - `tag[7:0]`: address of the held or in-flight word.
  - `tag_v`: tag valid.
  - `hi_byte`.
  - Timeout counter.
- **Miss:** `PC != tag` or `!tag_v`.
- **`EN_L`** = !(`state==VALID` && `tag_v` && `PC==tag`). This is combinational, so `EN_L` rises in the same cycle `PC` changes.
- **`IDLE`/`VALID` on miss:** `tag` ← `PC`, `tag_v` ← 1, go to `HI`.
- **`HI`:** `MEM_REQ`=1, `MEM_ADDR`=`tag`. On `MEM_ACK`: `hi_byte` ← `MEM_DATA`, go to `LO`.
- **`LO`:** `MEM_REQ`=1, `MEM_ADDR`=`tag+1` (mod 256; `8'hFF`→`8'h00`). On `MEM_ACK`: `Iin` ← {`hi_byte`, `MEM_DATA`}, go to `VALID`.
- **PC change while in `HI`/`LO`:** the outstanding byte request is never withdrawn early. The current byte completes, the data is discarded, and on that ack edge `tag` ← the new `PC` and the state goes to `HI`.
- **`Iin` holding:** `Iin` holds its last assembled value while `EN_L` is high and is never cleared except by reset.
- **Timeout:** the counter runs while `MEM_REQ` is high and unacked, and clears on ack or on state entry. When it reaches `ACK_TIMEOUT`:
  - `ERR` ← 1, `MEM_REQ` ← 0, `tag_v` ← 0, state goes to `IDLE`.
  - The unit then halts: no new fetch while `ERR`=1, and `EN_L` stays high.
  - `ERR` clears only on `RESET`.
- **Odd `PC`** is legal. There is no alignment check.

## Timing
- **Reset values:**
  - `Iin`=`16'h0000`, `EN_L`=1, `MEM_REQ`=0, `MEM_ADDR`=`8'h00`, `ERR`=0.
  - state=`IDLE`, `tag_v`=0, counter=0.
- **Reset mid-transaction:** `MEM_REQ` drops at the next edge regardless of ack. Memory must tolerate an abandoned request.
- **Latency:** let cycle 0 be the first cycle the new `PC` is presented, with zero-wait memory (ack in the first `MEM_REQ` cycle).
  - `MEM_REQ` is high for `tag` in cycle 1 and for `tag+1` in cycle 2.
  - `EN_L` is low in cycle 3.
  - Each wait cycle on either byte adds one cycle.
- **Back-to-back requests:** `MEM_REQ` stays high from `HI` to `LO`; only the address changes after the first ack.
- **`MEM_REQ`, `MEM_ADDR`, `Iin`** are registered or decoded from registered state. `EN_L` is the only output combinational in `PC`.
- **Timeout:** `ERR` rises on the edge ending the `ACK_TIMEOUT`-th unacked `MEM_REQ` cycle.

## Configuration
- **`FETCH_PREFETCH_EN` defined:** adds a one-word prefetch buffer (`pf_tag`, `pf_v`, `pf_word`).
  - In `VALID` with no miss, the unit fetches `tag+2` (mod 256) using the same `HI`/`LO` sequence into the buffer.
  - On a miss where `PC==pf_tag` and `pf_v`, on the next edge: `Iin` ← `pf_word`, `tag` ← `PC`, state goes to `VALID`. `EN_L` is therefore low in cycle 1.
  - A new prefetch then starts.
  - If `PC` moves while a prefetch is in flight, the current byte completes and is discarded, then `PC` is fetched normally.
  - Reset and timeout clear `pf_v`.
- **Undefined:** no buffer, and every `PC` change costs the full fetch latency.

## Structure
- **Package `fetch_pkg`:**
  - state enum (`IDLE`/`HI`/`LO`/`VALID`).
  - default `ACK_TIMEOUT`.
  - address increment constants (1, 2).
- **Sub-module `fetch_ack_timer`:** 8-bit counter with clear, enable and compare-to-`ACK_TIMEOUT`; outputs `expired`.
- **Top module** holds the FSM, tag logic, byte assembly and the optional prefetch buffer.

## Test plan
- **Reset then fetch:** `RESET` for 2 cycles, `PC`=`8'h00`, memory bytes `{00:8'h2A, 01:8'h45}`, zero-wait → `EN_L` low in cycle 3, `Iin`=`16'h2A45`.
- **Wait states:** `PC`=`8'h10`, ack delayed 3 cycles per byte → `MEM_ADDR` `8'h10` held 4 cycles, then `8'h11`; `EN_L` low in cycle 9.
- **Wrap:** `PC`=`8'hFF` → second `MEM_ADDR`=`8'h00`, `Iin`={mem[FF], mem[00]}.
- **PC change mid-fetch:** `PC` `8'h04`→`8'h20` during the `HI` wait → `MEM_REQ` stays high until ack, the byte is discarded, the next request is for `8'h20`, and `Iin` holds the word at `8'h20`.
- **Timeout:** `ACK_TIMEOUT`=4, `MEM_ACK` tied low → `ERR`=1 after 4 `MEM_REQ` cycles, `MEM_REQ`=0 thereafter, `EN_L`=1 until `RESET`.
- **Prefetch (`FETCH_PREFETCH_EN`):** `PC` `8'h00`, held until the prefetch of `8'h02` completes, then `PC`=`8'h02` → `EN_L` low the next cycle with `Iin`={mem[02], mem[03]}, and a request for `8'h04` starts.
